// File: rtl/layers_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : layers_frame_arbiter
// Purpose  : Round-robin, frame-atomic merge of LAYER_COUNT byte streams onto
//            a single AXI-Stream output. Optional stall watchdog is compiled in
//            with macro LAYERS_FRAME_ARBITER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module layers_frame_arbiter #(
   parameter int LAYER_COUNT = 5
) (
   input  logic                     clk_core,
   input  logic                     clk_core_rst,
   input  logic [LAYER_COUNT*8-1:0] s_axis_tdata,
   input  logic [LAYER_COUNT-1:0]   s_axis_tvalid,
   input  logic [LAYER_COUNT-1:0]   s_axis_tlast,
   output logic [LAYER_COUNT-1:0]   s_axis_tready,
   output logic [7:0]               m_axis_tdata,
   output logic [7:0]               m_axis_tdest,
   output logic                     m_axis_tvalid,
   output logic                     m_axis_tlast,
   input  logic                     m_axis_tready,
   input  logic [LAYER_COUNT-1:0]   cfg_layer_enable,
   input  logic [15:0]              cfg_timeout,
   input  logic                     cfg_timeout_clear,
   output logic [LAYER_COUNT-1:0]   status_grant,
   output logic [LAYER_COUNT-1:0]   status_timeout,
   output logic [LAYER_COUNT-1:0]   stat_frame_done
);

   localparam int IW = (LAYER_COUNT > 1) ? $clog2(LAYER_COUNT) : 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t                 r_state;
   logic [IW-1:0]          r_grant;
   logic [IW-1:0]          r_last_grant;
   logic [LAYER_COUNT-1:0] r_frame_done;

   logic [LAYER_COUNT-1:0] w_req;
   logic [LAYER_COUNT-1:0] w_grant_onehot;
   logic [IW-1:0]          w_idx;
   logic [IW-1:0]          w_next;
   logic                   w_found;
   logic                   w_in_grant;
   logic                   w_hs_last;
   logic                   w_timeout_fire;
   logic [7:0]             w_bytes [LAYER_COUNT];

   for (genvar i = 0; i < LAYER_COUNT; i++) begin : g_unpack
      assign w_bytes[i] = s_axis_tdata[i*8 +: 8];
   end

   assign w_req          = s_axis_tvalid & cfg_layer_enable;
   assign w_in_grant     = (r_state == ST_GRANT);
   assign w_grant_onehot = LAYER_COUNT'(1) << r_grant;
   assign w_hs_last      = w_in_grant & s_axis_tvalid[r_grant] & m_axis_tready
                         & s_axis_tlast[r_grant];

   // Rotating priority: the layer after the last winner is searched first.
   always_comb begin
      w_found = 1'b0;
      w_next  = '0;
      w_idx   = '0;
      for (int k = 1; k <= LAYER_COUNT; k++) begin
         w_idx = IW'((int'(r_last_grant) + k) % LAYER_COUNT);
         if (!w_found && w_req[w_idx]) begin
            w_found = 1'b1;
            w_next  = w_idx;
         end
      end
   end

   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tdest  = '0;
      s_axis_tready = '0;
      status_grant  = '0;
      if (w_in_grant) begin
         m_axis_tvalid = s_axis_tvalid[r_grant];
         m_axis_tdata  = w_bytes[r_grant];
         m_axis_tlast  = s_axis_tlast[r_grant];
         m_axis_tdest  = 8'(r_grant);
         s_axis_tready = w_grant_onehot & {LAYER_COUNT{m_axis_tready}};
         status_grant  = w_grant_onehot;
      end
   end

   assign stat_frame_done = r_frame_done;

   always_ff @(posedge clk_core or posedge clk_core_rst) begin
      if (clk_core_rst) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= IW'(LAYER_COUNT - 1);
         r_frame_done <= '0;
      end else begin
         r_frame_done <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant <= w_next;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_hs_last) begin
                  r_frame_done <= w_grant_onehot;
                  r_last_grant <= r_grant;
                  r_state      <= ST_IDLE;
               end else if (w_timeout_fire) begin
                  r_last_grant <= r_grant;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef LAYERS_FRAME_ARBITER_TIMEOUT_EN
   logic [15:0]            r_stall_cnt;
   logic [LAYER_COUNT-1:0] r_timeout;
   logic [15:0]            w_cnt_next;
   logic                   w_stall;

   assign w_stall        = w_in_grant & ~s_axis_tvalid[r_grant];
   assign w_cnt_next     = r_stall_cnt + 16'd1;
   // Fires on the cycle the stall count reaches the threshold.
   assign w_timeout_fire = w_stall && (cfg_timeout != 16'd0) && (w_cnt_next == cfg_timeout);
   assign status_timeout = r_timeout;

   always_ff @(posedge clk_core or posedge clk_core_rst) begin
      if (clk_core_rst) begin
         r_stall_cnt <= '0;
         r_timeout   <= '0;
      end else begin
         if (!w_stall || w_timeout_fire) begin
            r_stall_cnt <= '0;
         end else begin
            r_stall_cnt <= w_cnt_next;
         end
         r_timeout <= (cfg_timeout_clear ? '0 : r_timeout)
                    | (w_timeout_fire ? w_grant_onehot : '0);
      end
   end
`else
   logic w_unused;
   assign w_unused       = ^{cfg_timeout, cfg_timeout_clear};
   assign w_timeout_fire = 1'b0;
   assign status_timeout = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_layers_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_layers_frame_arbiter
// Purpose  : Directed vector table plus multi-cycle sequences for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layers_frame_arbiter;

   localparam int N = 5;

   logic           clk_core = 1'b0;
   logic           clk_core_rst;
   logic [N*8-1:0] s_axis_tdata;
   logic [N-1:0]   s_axis_tvalid;
   logic [N-1:0]   s_axis_tlast;
   logic [N-1:0]   s_axis_tready;
   logic [7:0]     m_axis_tdata;
   logic [7:0]     m_axis_tdest;
   logic           m_axis_tvalid;
   logic           m_axis_tlast;
   logic           m_axis_tready;
   logic [N-1:0]   cfg_layer_enable;
   logic [15:0]    cfg_timeout;
   logic           cfg_timeout_clear;
   logic [N-1:0]   status_grant;
   logic [N-1:0]   status_timeout;
   logic [N-1:0]   stat_frame_done;

   layers_frame_arbiter #(.LAYER_COUNT(N)) dut (
      .clk_core          (clk_core),
      .clk_core_rst      (clk_core_rst),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tlast      (s_axis_tlast),
      .s_axis_tready     (s_axis_tready),
      .m_axis_tdata      (m_axis_tdata),
      .m_axis_tdest      (m_axis_tdest),
      .m_axis_tvalid     (m_axis_tvalid),
      .m_axis_tlast      (m_axis_tlast),
      .m_axis_tready     (m_axis_tready),
      .cfg_layer_enable  (cfg_layer_enable),
      .cfg_timeout       (cfg_timeout),
      .cfg_timeout_clear (cfg_timeout_clear),
      .status_grant      (status_grant),
      .status_timeout    (status_timeout),
      .stat_frame_done   (stat_frame_done)
   );

   always #5 clk_core = ~clk_core;

   typedef struct {
      bit             rst_before;
      logic [N-1:0]   valid;
      logic [N-1:0]   last;
      logic [N*8-1:0] data;
      logic           e_mvalid;
      logic [7:0]     e_data;
      logic [7:0]     e_dest;
      logic           e_last;
      logic [N-1:0]   e_ready;
      logic [N-1:0]   e_grant;
      logic [N-1:0]   e_done;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic void add(bit r, logic [N-1:0] v, logic [N-1:0] l, logic [N*8-1:0] d,
                               logic mv, logic [7:0] ed, logic [7:0] edst, logic el,
                               logic [N-1:0] erdy, logic [N-1:0] eg, logic [N-1:0] edone);
      vec_t x;
      x.rst_before = r;  x.valid = v;    x.last = l;   x.data = d;
      x.e_mvalid = mv;   x.e_data = ed;  x.e_dest = edst; x.e_last = el;
      x.e_ready = erdy;  x.e_grant = eg; x.e_done = edone;
      tbl.push_back(x);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      s_axis_tdata  = '0;
      m_axis_tready = 1'b1;
      cfg_layer_enable  = '1;
      cfg_timeout_clear = 1'b0;
   endtask

   task automatic do_reset();
      clk_core_rst = 1'b1;
      idle_inputs();
      @(posedge clk_core); #1;
      check("reset_state",
            {m_axis_tvalid, s_axis_tready, status_grant, stat_frame_done, status_timeout},
            '0);
      clk_core_rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [N*8-1:0] rot;
      clk_core_rst = 1'b1;
      cfg_timeout  = '0;
      idle_inputs();

      // Layers 0 and 2 each send a 3-byte frame with an idle bubble between.
      add(1, 5'b00101, 5'b00000, 40'h00_00_C1_00_A1, 0, 8'h00, 8'd0, 0, 5'b00000, 5'b00000, 5'b00000);
      add(0, 5'b00101, 5'b00000, 40'h00_00_C1_00_A1, 1, 8'hA1, 8'd0, 0, 5'b00001, 5'b00001, 5'b00000);
      add(0, 5'b00101, 5'b00000, 40'h00_00_C1_00_A2, 1, 8'hA2, 8'd0, 0, 5'b00001, 5'b00001, 5'b00000);
      add(0, 5'b00101, 5'b00001, 40'h00_00_C1_00_A3, 1, 8'hA3, 8'd0, 1, 5'b00001, 5'b00001, 5'b00000);
      add(0, 5'b00100, 5'b00000, 40'h00_00_C1_00_00, 0, 8'h00, 8'd0, 0, 5'b00000, 5'b00000, 5'b00001);
      add(0, 5'b00100, 5'b00000, 40'h00_00_C1_00_00, 1, 8'hC1, 8'd2, 0, 5'b00100, 5'b00100, 5'b00000);
      add(0, 5'b00100, 5'b00000, 40'h00_00_C2_00_00, 1, 8'hC2, 8'd2, 0, 5'b00100, 5'b00100, 5'b00000);
      add(0, 5'b00100, 5'b00100, 40'h00_00_C3_00_00, 1, 8'hC3, 8'd2, 1, 5'b00100, 5'b00100, 5'b00000);
      add(0, 5'b00000, 5'b00000, 40'h00_00_00_00_00, 0, 8'h00, 8'd0, 0, 5'b00000, 5'b00000, 5'b00100);
      add(0, 5'b00000, 5'b00000, 40'h00_00_00_00_00, 0, 8'h00, 8'd0, 0, 5'b00000, 5'b00000, 5'b00000);

      // All layers request 1-byte frames: grants rotate 0..4,0 with bubbles.
      rot = 40'h14_13_12_11_10;
      for (int r = 0; r < 12; r++) begin
         int g;
         g = (r / 2) % N;
         if (r % 2 == 1)
            add(r == 0, '1, '1, rot, 1, 8'(8'h10 + g), 8'(g), 1, N'(1) << g, N'(1) << g, '0);
         else
            add(r == 0, '1, '1, rot, 0, 8'h00, 8'd0, 0, '0, '0,
                (r == 0) ? '0 : N'(1) << (((r / 2) - 1) % N));
      end

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst_before) do_reset();
         s_axis_tvalid = tbl[i].valid;
         s_axis_tlast  = tbl[i].last;
         s_axis_tdata  = tbl[i].data;
         @(negedge clk_core);
         check($sformatf("vec%0d", i),
               {m_axis_tvalid, s_axis_tready, status_grant, stat_frame_done,
                (tbl[i].e_mvalid ? {m_axis_tdata, m_axis_tdest, m_axis_tlast} : 17'd0)},
               {tbl[i].e_mvalid, tbl[i].e_ready, tbl[i].e_grant, tbl[i].e_done,
                (tbl[i].e_mvalid ? {tbl[i].e_data, tbl[i].e_dest, tbl[i].e_last} : 17'd0)});
         @(posedge clk_core); #1;
      end

      // Downstream backpressure toggling mid-frame on a 4-byte layer-1 frame.
      begin
         int idx = 0, beats = 0, lasts = 0, unstable = 0, order_bad = 0, extra = 0;
         logic [7:0] held = '0;
         bit have_held = 0;
         do_reset();
         for (int c = 0; c < 30 && idx < 4; c++) begin
            m_axis_tready     = (c % 2 == 0);
            s_axis_tvalid     = 5'b00010;
            s_axis_tlast      = (idx == 3) ? 5'b00010 : 5'b00000;
            s_axis_tdata      = '0;
            s_axis_tdata[15:8] = 8'(8'h51 + idx);
            @(negedge clk_core);
            if (have_held && m_axis_tvalid && m_axis_tdata !== held) unstable++;
            if (m_axis_tvalid && m_axis_tready) begin
               if (m_axis_tdata !== 8'(8'h51 + beats)) order_bad++;
               beats++;
               if (m_axis_tlast) lasts++;
               have_held = 0;
               idx++;
            end else if (m_axis_tvalid) begin
               held = m_axis_tdata;
               have_held = 1;
            end
            @(posedge clk_core); #1;
         end
         s_axis_tvalid = '0; s_axis_tlast = '0; m_axis_tready = 1'b1;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk_core);
            if (m_axis_tvalid) extra++;
            @(posedge clk_core); #1;
         end
         check("bp_beats", 64'(beats), 64'd4);
         check("bp_tlast_count", 64'(lasts), 64'd1);
         check("bp_stable_hold", 64'(unstable + order_bad), 64'd0);
         check("bp_no_extra_beats", 64'(extra), 64'd0);
      end

      // Layer 1 disabled mid-frame: frame completes, never granted again.
      begin
         int idx1 = 0, b1 = 0, l1 = 0, regrant = 0, g3 = 0, dest_bad = 0;
         do_reset();
         for (int c = 0; c < 40; c++) begin
            s_axis_tvalid = 5'b01010;
            s_axis_tlast  = {1'b0, 1'b1, 1'b0, (idx1 % 3 == 2), 1'b0};
            s_axis_tdata  = {8'h00, 8'h77, 8'h00, 8'(8'h61 + idx1), 8'h00};
            @(negedge clk_core);
            if (l1 > 0 && status_grant[1]) regrant++;
            if (s_axis_tready[1] && s_axis_tvalid[1]) begin
               if (m_axis_tdest !== 8'd1 || m_axis_tdata !== 8'(8'h61 + idx1)) dest_bad++;
               b1++; idx1++;
               if (m_axis_tlast) l1++;
            end
            if (s_axis_tready[3] && s_axis_tvalid[3]) g3++;
            @(posedge clk_core); #1;
            if (idx1 >= 1) cfg_layer_enable[1] = 1'b0;
         end
         check("dis_layer1_beats", 64'(b1), 64'd3);
         check("dis_layer1_tlast", 64'(l1), 64'd1);
         check("dis_no_regrant", 64'(regrant + dest_bad), 64'd0);
         check("dis_layer3_frames", 64'(g3), 64'd18);
      end

      // Layer 3 stalls after 2 beats with an 8-cycle watchdog threshold.
      begin
         int idx = 0, held_cyc = 0, lasts = 0;
         do_reset();
         cfg_timeout = 16'd8;
         for (int c = 0; c < 30; c++) begin
            s_axis_tvalid = (idx < 2) ? 5'b01000 : 5'b00000;
            s_axis_tdata  = {8'h00, 8'(8'h31 + idx), 24'h0};
            @(negedge clk_core);
            if (status_grant == 5'b01000 && !m_axis_tvalid) held_cyc++;
            if (m_axis_tvalid && m_axis_tlast) lasts++;
            if (s_axis_tready[3] && s_axis_tvalid[3]) idx++;
            @(posedge clk_core); #1;
         end
         @(negedge clk_core);
`ifdef LAYERS_FRAME_ARBITER_TIMEOUT_EN
         check("to_held_cycles", 64'(held_cyc), 64'd8);
         check("to_status_set", 64'(status_timeout), 64'h08);
`else
         check("to_held_cycles", 64'(held_cyc), 64'd27);
         check("to_status_zero", 64'(status_timeout), 64'h00);
`endif
         check("to_no_tlast", 64'(lasts), 64'd0);
         @(posedge clk_core); #1;
         cfg_timeout_clear = 1'b1;
         @(posedge clk_core); #1;
         cfg_timeout_clear = 1'b0;
         @(negedge clk_core);
         check("to_status_cleared", 64'(status_timeout), 64'h00);
`ifdef LAYERS_FRAME_ARBITER_TIMEOUT_EN
         // Released on layer 3, so the search resumes at layer 4.
         @(posedge clk_core); #1;
         s_axis_tvalid = 5'b10100;
         @(posedge clk_core); #1;
         @(negedge clk_core);
         check("to_next_grant", 64'(status_grant), 64'h10);
`endif
         @(posedge clk_core); #1;
         cfg_timeout = '0;
      end

      // Asynchronous reset in the middle of a layer-4 frame.
      begin
         int lasts = 0;
         do_reset();
         s_axis_tvalid = 5'b10000;
         s_axis_tdata  = {8'h41, 32'h0};
         @(posedge clk_core); #1;
         @(posedge clk_core); #1;
         s_axis_tdata  = {8'h42, 32'h0};
         #2;
         clk_core_rst  = 1'b1;
         #1;
         check("arst_async_outputs",
               {m_axis_tvalid, s_axis_tready, status_grant, stat_frame_done, status_timeout},
               '0);
         s_axis_tvalid = 5'b10100;
         s_axis_tdata  = {8'h42, 8'h00, 8'h22, 16'h0};
         @(posedge clk_core); #1;
         clk_core_rst  = 1'b0;
         @(negedge clk_core);
         if (m_axis_tvalid && m_axis_tlast) lasts++;
         check("arst_idle_after", 64'(status_grant), 64'h00);
         @(posedge clk_core); #1;
         @(negedge clk_core);
         if (m_axis_tvalid && m_axis_tlast) lasts++;
         check("arst_first_grant", {32'(status_grant), 8'(m_axis_tdest), m_axis_tdata},
               {32'h04, 8'd2, 8'h22});
         check("arst_no_tlast", 64'(lasts), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
